// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_pkg
// Description : Shared mode encoding and duty constants for the LED bank.
// Revision    : 1.0 - initial release
// ============================================================================
package led_pkg;

    typedef enum logic [1:0] {
        LED_OFF   = 2'd0,
        LED_ON    = 2'd1,
        LED_BLINK = 2'd2,
        LED_PULSE = 2'd3
    } led_mode_t;

    localparam int              DUTY_W    = 4;
    localparam logic [DUTY_W-1:0] DUTY_FULL = 4'hF;

endpackage
`default_nettype wire

// File: rtl/led_blinker_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : led_blinker_bank_if
// Description : Channel configuration write bus for the LED bank.
// Revision    : 1.0 - initial release
// ============================================================================
interface led_blinker_bank_if #(
    parameter int N_LED    = 8,
    parameter int PERIOD_W = 16
) ();
    logic                     cfg_we;
    logic [$clog2(N_LED):0]   cfg_sel;
    logic [1:0]               cfg_mode;
    logic [PERIOD_W-1:0]      cfg_half;
    logic [3:0]               cfg_duty;

    modport master (output cfg_we, cfg_sel, cfg_mode, cfg_half, cfg_duty);
    modport slave  (input  cfg_we, cfg_sel, cfg_mode, cfg_half, cfg_duty);
endinterface
`default_nettype wire

// File: rtl/led_channel.sv
`default_nettype none
// ============================================================================
// Module      : led_channel
// Description : One LED channel: mode/half/duty registers, tick counter, FSM.
//               Duty register and PWM gating exist only with LED_PWM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module led_channel
    import led_pkg::*;
#(
    parameter int PERIOD_W     = 16,
    parameter int DEFAULT_HALF = 500
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                tick_i,
    input  logic                trig_i,
    input  logic                wr_i,
    input  led_mode_t           mode_i,
    input  logic [PERIOD_W-1:0] half_i,
`ifdef LED_PWM_EN
    input  logic [DUTY_W-1:0]   duty_i,
    input  logic [DUTY_W-1:0]   pwm_nxt_i,
`endif
    output logic                led_o,
    output logic                busy_o
);

    led_mode_t           mode_q, mode_d;
    logic [PERIOD_W-1:0] half_q, half_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                phase_q, phase_d;
    logic                busy_q, busy_d;
    logic                last_w;

    // A stored half of 0 is treated as 1, so terminal count is then 0.
    assign last_w = (half_q == '0) ? (cnt_q == '0)
                                   : (cnt_q == half_q - PERIOD_W'(1));

    always_comb begin
        mode_d  = mode_q;
        half_d  = half_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        busy_d  = busy_q;
        if (wr_i) begin
            mode_d  = mode_i;
            half_d  = half_i;
            cnt_d   = '0;
            phase_d = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (mode_q)
                LED_OFF: begin
                    phase_d = 1'b0;
                    busy_d  = 1'b0;
                end
                LED_ON: begin
                    phase_d = 1'b1;
                    busy_d  = 1'b0;
                end
                LED_BLINK: begin
                    if (tick_i) begin
                        if (last_w) begin
                            phase_d = ~phase_q;
                            cnt_d   = '0;
                        end else begin
                            cnt_d   = cnt_q + PERIOD_W'(1);
                        end
                    end
                end
                LED_PULSE: begin
                    if (trig_i) begin
                        phase_d = 1'b1;
                        busy_d  = 1'b1;
                        cnt_d   = '0;
                    end else if (busy_q && tick_i) begin
                        if (last_w) begin
                            phase_d = 1'b0;
                            busy_d  = 1'b0;
                            cnt_d   = '0;
                        end else begin
                            cnt_d   = cnt_q + PERIOD_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            mode_q  <= LED_OFF;
            half_q  <= PERIOD_W'(DEFAULT_HALF);
            cnt_q   <= '0;
            phase_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            half_q  <= half_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            busy_q  <= busy_d;
        end
    end

    assign busy_o = busy_q;

`ifdef LED_PWM_EN
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic              led_q;

    assign duty_d = wr_i ? duty_i : duty_q;

    // Gate against the pwm value that will be current after this edge.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            duty_q <= DUTY_FULL;
            led_q  <= 1'b0;
        end else begin
            duty_q <= duty_d;
            led_q  <= phase_d & (pwm_nxt_i <= duty_d);
        end
    end

    assign led_o = led_q;
`else
    assign led_o = phase_q;
`endif

endmodule
`default_nettype wire

// File: rtl/led_blinker_bank.sv
`default_nettype none
// ============================================================================
// Module      : led_blinker_bank
// Description : N_LED independent LED drivers sharing one tick prescaler.
//               Optional PWM brightness when LED_PWM_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module led_blinker_bank
    import led_pkg::*;
#(
    parameter int N_LED        = 8,
    parameter int CLK_HZ       = 100000000,
    parameter int TICK_HZ      = 1000,
    parameter int PERIOD_W     = 16,
    parameter int DEFAULT_HALF = 500
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    led_blinker_bank_if.slave  cfg,
    input  logic [N_LED-1:0]   trig_i,
    output logic [N_LED-1:0]   led_o,
    output logic [N_LED-1:0]   busy_o,
    output logic               tick_o
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SEL_W = $clog2(N_LED) + 1;

    logic [CNT_W-1:0] pre_q, pre_d;
    logic             tick_q, tick_d;
    logic [N_LED-1:0] wr_w;

    // tick is registered so it is high exactly while the count sits at DIV-1.
    always_comb begin
        pre_d  = (pre_q == CNT_W'(DIV - 1)) ? '0 : pre_q + CNT_W'(1);
        tick_d = (pre_d == CNT_W'(DIV - 1));
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

`ifdef LED_PWM_EN
    logic [DUTY_W-1:0] pwm_q, pwm_d;

    assign pwm_d = pwm_q + DUTY_W'(1);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) pwm_q <= '0;
        else         pwm_q <= pwm_d;
    end
`else
    logic unused_duty_w;
    assign unused_duty_w = ^cfg.cfg_duty;
`endif

    for (genvar k = 0; k < N_LED; k++) begin : g_ch
        assign wr_w[k] = cfg.cfg_we && (cfg.cfg_sel == SEL_W'(k));

        led_channel #(
            .PERIOD_W     (PERIOD_W),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_ch (
            .sys_clk   (sys_clk),
            .sys_rst   (sys_rst),
            .tick_i    (tick_q),
            .trig_i    (trig_i[k]),
            .wr_i      (wr_w[k]),
            .mode_i    (led_mode_t'(cfg.cfg_mode)),
            .half_i    (cfg.cfg_half),
`ifdef LED_PWM_EN
            .duty_i    (cfg.cfg_duty),
            .pwm_nxt_i (pwm_d),
`endif
            .led_o     (led_o[k]),
            .busy_o    (busy_o[k])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_led_blinker_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_blinker_bank
// Description : Directed table-driven bench for led_blinker_bank (N_LED=4, DIV=5).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_blinker_bank;

    localparam int N = 4;

    logic         clk;
    logic         rst;
    logic [N-1:0] trig;
    logic [N-1:0] led;
    logic [N-1:0] busy;
    logic         tick;

    int n_tests = 0;
    int n_fail  = 0;

    led_blinker_bank_if #(.N_LED(N), .PERIOD_W(16)) cfg_if ();

    led_blinker_bank #(
        .N_LED        (N),
        .CLK_HZ       (50),
        .TICK_HZ      (10),
        .PERIOD_W     (16),
        .DEFAULT_HALF (500)
    ) dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .cfg     (cfg_if),
        .trig_i  (trig),
        .led_o   (led),
        .busy_o  (busy),
        .tick_o  (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic       we;
        logic [2:0] sel;
        logic [1:0] mode;
        logic [15:0] half;
        logic [3:0] trig;
        int         n;
        logic [3:0] led;
        logic [3:0] busy;
        logic       tk;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(string nm, bit we, int sel, int mode, int half,
                                int tr, int n, int ld, int bs, bit tk);
        vec_t v;
        v.nm = nm; v.we = we; v.sel = 3'(sel); v.mode = 2'(mode);
        v.half = 16'(half); v.trig = 4'(tr); v.n = n;
        v.led = 4'(ld); v.busy = 4'(bs); v.tk = tk;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        cfg_if.cfg_we   = 1'b0;
        cfg_if.cfg_sel  = '0;
        cfg_if.cfg_mode = '0;
        cfg_if.cfg_half = '0;
        cfg_if.cfg_duty = 4'hF;
        trig            = '0;
    endtask

    initial begin
        int highs;
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        check("rst_led",  32'(led),  0);
        check("rst_busy", 32'(busy), 0);
        check("rst_tick", 32'(tick), 0);
        rst = 1'b0;

        // Edge numbers in names count from the last reset edge (E0).
        vq.push_back(mk("E4 first tick",      0,0,0,0, 0, 3, 4'b0000,4'b0000,1));
        vq.push_back(mk("E9 second tick",     0,0,0,0, 0, 4, 4'b0000,4'b0000,1));
        vq.push_back(mk("E10 tick low",       0,0,0,0, 0, 0, 4'b0000,4'b0000,0));
        vq.push_back(mk("E11 wr ch1 blink3",  1,1,2,3, 0, 0, 4'b0000,4'b0000,0));
        vq.push_back(mk("E24 blink still low",0,0,0,0, 0,12, 4'b0000,4'b0000,1));
        vq.push_back(mk("E25 blink rises",    0,0,0,0, 0, 0, 4'b0010,4'b0000,0));
        vq.push_back(mk("E39 blink high",     0,0,0,0, 0,13, 4'b0010,4'b0000,1));
        vq.push_back(mk("E40 blink falls",    0,0,0,0, 0, 0, 4'b0000,4'b0000,0));
        vq.push_back(mk("E41 wr ch2 pulse4",  1,2,3,4, 0, 0, 4'b0000,4'b0000,0));
        vq.push_back(mk("E42 trig ch2",       0,0,0,0, 4, 0, 4'b0100,4'b0100,0));
        vq.push_back(mk("E54 pulse held",     0,0,0,0, 0,11, 4'b0100,4'b0100,1));
        vq.push_back(mk("E55 blink+pulse",    0,0,0,0, 0, 0, 4'b0110,4'b0100,0));
        vq.push_back(mk("E59 pulse last",     0,0,0,0, 0, 3, 4'b0110,4'b0100,1));
        vq.push_back(mk("E60 pulse ends",     0,0,0,0, 0, 0, 4'b0010,4'b0000,0));
        vq.push_back(mk("E61 trig again",     0,0,0,0, 4, 0, 4'b0110,4'b0100,0));
        vq.push_back(mk("E69 pulse held",     0,0,0,0, 0, 7, 4'b0110,4'b0100,1));
        vq.push_back(mk("E70 retrig on tick", 0,0,0,0, 4, 0, 4'b0100,4'b0100,0));
        vq.push_back(mk("E89 extended pulse", 0,0,0,0, 0,18, 4'b0110,4'b0100,1));
        vq.push_back(mk("E90 extended ends",  0,0,0,0, 0, 0, 4'b0010,4'b0000,0));
        vq.push_back(mk("E93 sel5 ignored",   1,5,0,1, 0, 2, 4'b0010,4'b0000,0));
        vq.push_back(mk("E94 wr ch3 half0",   1,3,2,0, 0, 0, 4'b0010,4'b0000,1));
        vq.push_back(mk("E95 half0 toggles",  0,0,0,0, 2, 0, 4'b1010,4'b0000,0));
        vq.push_back(mk("E100 both low",      0,0,0,0, 0, 4, 4'b0000,4'b0000,0));
        vq.push_back(mk("E105 ch3 high",      0,0,0,0, 0, 4, 4'b1000,4'b0000,0));
        vq.push_back(mk("E106 wr+trig ch2",   1,2,3,4, 4, 0, 4'b1000,4'b0000,0));
        vq.push_back(mk("E108 no pulse",      0,0,0,0, 0, 1, 4'b1000,4'b0000,0));
        vq.push_back(mk("E109 pre-tick",      0,0,0,0, 0, 0, 4'b1000,4'b0000,1));
        vq.push_back(mk("E110 wr on tick",    1,3,2,2, 0, 0, 4'b0000,4'b0000,0));
        vq.push_back(mk("E115 ch3 cnt 1",     0,0,0,0, 0, 4, 4'b0010,4'b0000,0));
        vq.push_back(mk("E120 ch3 rises",     0,0,0,0, 0, 4, 4'b1010,4'b0000,0));
        vq.push_back(mk("E121 wr ch0 on",     1,0,1,7, 0, 0, 4'b1010,4'b0000,0));
        vq.push_back(mk("E122 ch0 on",        0,0,0,0, 0, 0, 4'b1011,4'b0000,0));

        foreach (vq[i]) begin
            cfg_if.cfg_we   = vq[i].we;
            cfg_if.cfg_sel  = vq[i].sel;
            cfg_if.cfg_mode = vq[i].mode;
            cfg_if.cfg_half = vq[i].half;
            trig            = vq[i].trig;
            step();
            idle_inputs();
            repeat (vq[i].n) step();
            check({vq[i].nm, " led"},  32'(led),  32'(vq[i].led));
            check({vq[i].nm, " busy"}, 32'(busy), 32'(vq[i].busy));
            check({vq[i].nm, " tick"}, 32'(tick), 32'(vq[i].tk));
        end

`ifdef LED_PWM_EN
        cfg_if.cfg_we = 1'b1; cfg_if.cfg_sel = 3'd0; cfg_if.cfg_mode = 2'd1;
        cfg_if.cfg_half = 16'd1; cfg_if.cfg_duty = 4'd3;
        step();
        idle_inputs();
        step();
        highs = 0;
        for (int c = 0; c < 16; c++) begin
            step();
            highs += int'(led[0]);
        end
        check("pwm duty3 highs", 32'(highs), 4);
        cfg_if.cfg_we = 1'b1; cfg_if.cfg_sel = 3'd0; cfg_if.cfg_mode = 2'd1;
        cfg_if.cfg_half = 16'd1; cfg_if.cfg_duty = 4'd15;
        step();
        idle_inputs();
        step();
        highs = 0;
        for (int c = 0; c < 16; c++) begin
            step();
            highs += int'(led[0]);
        end
        check("pwm duty15 highs", 32'(highs), 16);
`else
        highs = 0;
`endif

        // Reset mid-blink/mid-pulse: outputs clear on the very next edge.
        trig = 4'b0100;
        cfg_if.cfg_we = 1'b1; cfg_if.cfg_sel = 3'd2; cfg_if.cfg_mode = 2'd3;
        cfg_if.cfg_half = 16'd9;
        step();
        idle_inputs();
        trig = 4'b0100;
        step();
        trig = '0;
        check("pre-rst busy2", 32'(busy[2]), 1);
        rst = 1'b1;
        step();
        check("midrst led",  32'(led),  0);
        check("midrst busy", 32'(busy), 0);
        check("midrst tick", 32'(tick), 0);
        rst = 1'b0;
        repeat (4) step();
        check("post-rst tick", 32'(tick), 1);
        repeat (20) step();
        check("post-rst led off", 32'(led), 0);
        trig = 4'b1111;
        step();
        trig = '0;
        check("post-rst trig ignored", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
